pic_ctrl_gen: RTL

PIC_CTRL_GEN -- requirements
Module: pic_ctrl_gen

---
 rtl/pic_ctrl_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pic_ctrl_gen.sv
// Programmable interrupt controller: masked edge/level requests, fully nested priority, IDLE/REQ/ACK handshake.
// Optional rotating priority is compiled in with `define PIC_ROTATE_EN.
module pic_ctrl_gen #(
    parameter int NUM_IRQ = 8,
    parameter int IDW     = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               int_o,
    input  logic               inta,
    output logic               vec_valid,
    output logic [7:0]         vec
);
    localparam logic [1:0]         ST_IDLE = 2'd0;
    localparam logic [1:0]         ST_REQ  = 2'd1;
    localparam logic [1:0]         ST_ACK  = 2'd2;
    localparam logic [IDW-1:0]     PTR_RST = IDW'(NUM_IRQ - 1);
    localparam logic [NUM_IRQ-1:0] ONE     = NUM_IRQ'(1);

    // Rank 0 is the highest priority; channel prio_ptr+1 holds rank 0.
    function automatic logic [IDW-1:0] rank(input logic [IDW-1:0] ch, input logic [IDW-1:0] ptr);
        int r;
        r = int'(ch) + NUM_IRQ - 1 - int'(ptr);
        if (r >= NUM_IRQ) r = r - NUM_IRQ;
        return IDW'(r);
    endfunction

    function automatic logic [IDW:0] pick(input logic [NUM_IRQ-1:0] v, input logic [IDW-1:0] ptr);
        logic           found;
        logic [IDW-1:0] id;
        logic [IDW-1:0] best;
        found = 1'b0;
        id    = '0;
        best  = '1;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i] && (!found || rank(IDW'(i), ptr) < best)) begin
                found = 1'b1;
                id    = IDW'(i);
                best  = rank(IDW'(i), ptr);
            end
        end
        return {found, id};
    endfunction

    logic [1:0]         state, state_n;
    logic [NUM_IRQ-1:0] imr, irr, isr, irq_q;
    logic [7:0]         vbase;
    logic               ltim, aeoi;
    logic [IDW-1:0]     prio_ptr;

    logic [NUM_IRQ-1:0] edge_v, cand, eoi_sel, isr_eoi, ack_sel;
    logic               cand_f, isr_f, isre_f, int_cond, eoi_hit, ack, ack_ok;
    logic [IDW-1:0]     cand_id, isr_id, isre_id, eoi_ch;
    logic               unused_sink;

    always_comb begin
        edge_v            = irq & ~irq_q;
        cand              = irr & ~imr;
        {cand_f, cand_id} = pick(cand, prio_ptr);
        {isr_f, isr_id}   = pick(isr, prio_ptr);
        int_cond = cand_f && (!isr_f || rank(cand_id, prio_ptr) < rank(isr_id, prio_ptr));

        // EOI is folded into ISR before the acknowledge winner is judged.
        eoi_sel = '0;
        eoi_ch  = '0;
        if (wr_en && wr_addr == 2'd3) begin
            if (wr_data[7]) begin
                eoi_sel = ONE << wr_data[IDW-1:0];
                eoi_ch  = wr_data[IDW-1:0];
            end else if (isr_f) begin
                eoi_sel = ONE << isr_id;
                eoi_ch  = isr_id;
            end
        end
        eoi_sel           = eoi_sel & isr;
        eoi_hit           = |eoi_sel;
        isr_eoi           = isr & ~eoi_sel;
        {isre_f, isre_id} = pick(isr_eoi, prio_ptr);

        ack     = (state == ST_REQ) && inta;
        ack_ok  = ack && cand_f && (!isre_f || rank(cand_id, prio_ptr) < rank(isre_id, prio_ptr));
        ack_sel = ack_ok ? (ONE << cand_id) : '0;

        case (state)
            ST_IDLE: state_n = int_cond ? ST_REQ : ST_IDLE;
            ST_REQ:  state_n = ack ? ST_ACK : (int_cond ? ST_REQ : ST_IDLE);
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            2'd0:    rd_data[NUM_IRQ-1:0] = imr;
            2'd1:    rd_data[NUM_IRQ-1:0] = irr;
            2'd2:    rd_data[NUM_IRQ-1:0] = isr;
            default: begin
                rd_data[9:8]     = state;
                rd_data[IDW-1:0] = prio_ptr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imr       <= '1;
            vbase     <= 8'h08;
            ltim      <= 1'b0;
            aeoi      <= 1'b0;
            irr       <= '0;
            isr       <= '0;
            irq_q     <= '0;
            state     <= ST_IDLE;
            int_o     <= 1'b0;
            vec_valid <= 1'b0;
            vec       <= 8'h00;
        end else begin
            irq_q <= irq;
            if (wr_en) begin
                case (wr_addr)
                    2'd0: imr   <= wr_data[NUM_IRQ-1:0];
                    2'd1: vbase <= wr_data[7:0];
                    2'd2: begin
                        ltim <= wr_data[0];
                        aeoi <= wr_data[1];
                    end
                    default: ;
                endcase
            end
            // A fresh edge outranks the acknowledge clear of the same channel.
            irr       <= ltim ? irq : ((irr & ~ack_sel) | edge_v);
            isr       <= isr_eoi | (aeoi ? '0 : ack_sel);
            state     <= state_n;
            int_o     <= (state_n == ST_REQ);
            vec_valid <= (state_n == ST_ACK);
            if (ack) vec <= vbase + (ack_ok ? 8'(cand_id) : 8'(NUM_IRQ - 1));
        end
    end

`ifdef PIC_ROTATE_EN
    logic rot;

    always_ff @(posedge clk) begin
        if (reset) begin
            rot      <= 1'b0;
            prio_ptr <= PTR_RST;
        end else begin
            if (wr_en && wr_addr == 2'd2) rot <= wr_data[2];
            if (rot) begin
                if (ack_ok && aeoi) prio_ptr <= cand_id;
                else if (eoi_hit)   prio_ptr <= eoi_ch;
            end
        end
    end
`else
    assign prio_ptr = PTR_RST;
`endif

    assign unused_sink = ^{wr_data, eoi_ch, eoi_hit};

endmodule
